// File: rtl/router_pkt_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_pkt_fifo_if                                              |
// | Purpose  : Handshake and status bundle between router FSM and packet FIFO. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface router_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  soft_reset;
  logic                  write_enb;
  logic                  read_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [AW:0]           fill_level;
  logic                  pkt_active;
  logic                  pkt_done;
  logic                  wr_err;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, empty, full, almost_full, fill_level, pkt_active, pkt_done, wr_err
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, empty, full, almost_full, fill_level, pkt_active, pkt_done, wr_err
  );
endinterface
`default_nettype wire

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_pkt_fifo                                                 |
// | Purpose  : Router output FIFO tagging headers and tracking packet bounds.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2
) (
  input  logic             clock,
  input  logic             reset,
  router_pkt_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_af_margin = (AW+1)'(AF_MARGIN);
  localparam logic [AW:0] c_ptr_one   = (AW+1)'(1);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_lfd_d;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [7:0]            r_pkt_cnt;
  logic                  r_pkt_active;
  logic                  r_pkt_done;
  logic                  r_wr_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [AW:0]           w_fill;
  logic [AW:0]           w_free;
  logic [DATA_WIDTH:0]   w_rd_entry;
  logic [7:0]            w_hdr_len;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A flush owns the cycle, so neither side may move a pointer alongside it
  assign w_wr_ok    = bus.write_enb && !w_full  && !bus.soft_reset;
  assign w_rd_ok    = bus.read_enb  && !w_empty && !bus.soft_reset;
  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_free     = c_depth - w_fill;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  // Header length field counts payload bytes; the extra one covers parity
  assign w_hdr_len  = 8'(w_rd_entry[DATA_WIDTH-1:2]) + 8'd1;

  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_lfd_d, bus.data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_lfd_d      <= 1'b0;
      r_data_out   <= '0;
      r_pkt_cnt    <= 8'd0;
      r_pkt_active <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_wr_err     <= 1'b0;
    end else if (bus.soft_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_lfd_d      <= 1'b0;
      r_data_out   <= '0;
      r_pkt_cnt    <= 8'd0;
      r_pkt_active <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_lfd_d    <= bus.lfd_state;
      r_pkt_done <= 1'b0;
      r_wr_err   <= bus.write_enb && w_full;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
        r_data_out <= w_rd_entry[DATA_WIDTH-1:0];
        if (w_rd_entry[DATA_WIDTH]) begin
          // A header always restarts the count, even over a truncated packet
          r_pkt_cnt    <= w_hdr_len;
          r_pkt_active <= 1'b1;
        end else if (r_pkt_cnt != 8'd0) begin
          r_pkt_cnt <= r_pkt_cnt - 8'd1;
          if (r_pkt_cnt == 8'd1) begin
            r_pkt_active <= 1'b0;
            r_pkt_done   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (w_free <= c_af_margin);
  assign bus.fill_level  = w_fill;
  assign bus.pkt_active  = r_pkt_active;
  assign bus.pkt_done    = r_pkt_done;
  assign bus.wr_err      = r_wr_err;
endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_router_pkt_fifo                                              |
// | Purpose  : Directed self-checking bench for router_pkt_fifo.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_router_pkt_fifo;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int AF_MARGIN  = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  router_pkt_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AF_MARGIN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.write_enb = 1'b1;
    bus.data_in   = d;
    tick();
    bus.write_enb = 1'b0;
  endtask

  // Header flag follows lfd_state from the edge before the header write
  task automatic push_hdr(input logic [7:0] d);
    bus.lfd_state = 1'b1;
    tick();
    bus.lfd_state = 1'b0;
    push(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.soft_reset = 1'b0; bus.write_enb = 1'b0; bus.read_enb = 1'b0;
    bus.lfd_state = 1'b0;  bus.data_in = 8'h00;
    tick(); tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0h exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got=%0h exp=0", bus.full); end
    checks++; if (bus.fill_level !== 5'd0) begin errors++; $display("FAIL rst_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got=%0h exp=0", bus.data_out); end
    checks++; if (bus.pkt_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%0h exp=0", bus.pkt_active); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", bus.pkt_done); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL rst_wrerr got=%0h exp=0", bus.wr_err); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got=%0h exp=0", bus.almost_full); end
    reset = 1'b0;
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [5]    = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
    logic       exp_act [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    push_hdr(8'h0C); push(8'hA1); push(8'hA2); push(8'hA3); push(8'h5E);
    checks++; if (bus.fill_level !== 5'd5) begin errors++; $display("FAIL pkt_fill got=%0d exp=5", bus.fill_level); end
    checks++; if (bus.pkt_active !== 1'b0) begin errors++; $display("FAIL pkt_pre_active got=%0h exp=0", bus.pkt_active); end
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) bus.read_enb = 1'b0;
      checks++; if (bus.data_out !== exp_d[i]) begin errors++; $display("FAIL pkt_dout[%0d] got=%0h exp=%0h", i, bus.data_out, exp_d[i]); end
      checks++; if (bus.pkt_active !== exp_act[i]) begin errors++; $display("FAIL pkt_active[%0d] got=%0h exp=%0h", i, bus.pkt_active, exp_act[i]); end
      checks++; if (bus.pkt_done !== exp_done[i]) begin errors++; $display("FAIL pkt_done[%0d] got=%0h exp=%0h", i, bus.pkt_done, exp_done[i]); end
    end
    tick();
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_end got=%0h exp=0", bus.pkt_done); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pkt_empty got=%0h exp=1", bus.empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      logic exp_af;
      logic exp_full;
      exp_af   = (i + 1) >= 14;
      exp_full = (i == 15);
      push(8'h10 + 8'(i));
      checks++; if (bus.fill_level !== 5'(i + 1)) begin errors++; $display("FAIL full_fill[%0d] got=%0d exp=%0d", i, bus.fill_level, i + 1); end
      checks++; if (bus.almost_full !== exp_af) begin errors++; $display("FAIL full_af[%0d] got=%0h exp=%0h", i, bus.almost_full, exp_af); end
      checks++; if (bus.full !== exp_full) begin errors++; $display("FAIL full_full[%0d] got=%0h exp=%0h", i, bus.full, exp_full); end
    end
    push(8'hEE);
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL ovf_wrerr got=%0h exp=1", bus.wr_err); end
    checks++; if (bus.fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill got=%0d exp=16", bus.fill_level); end
    tick();
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL ovf_wrerr_clr got=%0h exp=0", bus.wr_err); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    bus.write_enb = 1'b1; bus.read_enb = 1'b1; bus.data_in = 8'hF0;
    tick();
    checks++; if (bus.data_out !== 8'h10) begin errors++; $display("FAIL frw_dout0 got=%0h exp=10", bus.data_out); end
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL frw_wrerr0 got=%0h exp=1", bus.wr_err); end
    checks++; if (bus.fill_level !== 5'd15) begin errors++; $display("FAIL frw_fill0 got=%0d exp=15", bus.fill_level); end
    bus.data_in = 8'hF1;
    tick();
    bus.write_enb = 1'b0;
    checks++; if (bus.data_out !== 8'h11) begin errors++; $display("FAIL frw_dout1 got=%0h exp=11", bus.data_out); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL frw_wrerr1 got=%0h exp=0", bus.wr_err); end
    checks++; if (bus.fill_level !== 5'd15) begin errors++; $display("FAIL frw_fill1 got=%0d exp=15", bus.fill_level); end
    for (int i = 0; i < 15; i++) begin
      tick();
      exp = (i < 14) ? 8'h12 + 8'(i) : 8'hF1;
      checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL drain_dout[%0d] got=%0h exp=%0h", i, bus.data_out, exp); end
      checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL drain_done[%0d] got=%0h exp=0", i, bus.pkt_done); end
    end
    bus.read_enb = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0h exp=1", bus.empty); end
  endtask

  task automatic test_empty_rw();
    bus.write_enb = 1'b1; bus.read_enb = 1'b1; bus.data_in = 8'h3C;
    tick();
    bus.write_enb = 1'b0;
    checks++; if (bus.fill_level !== 5'd1) begin errors++; $display("FAIL erw_fill got=%0d exp=1", bus.fill_level); end
    checks++; if (bus.data_out !== 8'hF1) begin errors++; $display("FAIL erw_hold got=%0h exp=f1", bus.data_out); end
    tick();
    bus.read_enb = 1'b0;
    checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL erw_dout got=%0h exp=3c", bus.data_out); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL erw_empty got=%0h exp=1", bus.empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      push(8'h40 + 8'(i));
      checks++; if (bus.fill_level !== 5'd1) begin errors++; $display("FAIL wrap_fill_w[%0d] got=%0d exp=1", i, bus.fill_level); end
      bus.read_enb = 1'b1;
      tick();
      bus.read_enb = 1'b0;
      checks++; if (bus.data_out !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_dout[%0d] got=%0h exp=%0h", i, bus.data_out, 8'h40 + 8'(i)); end
      checks++; if (bus.fill_level !== 5'd0) begin errors++; $display("FAIL wrap_fill_r[%0d] got=%0d exp=0", i, bus.fill_level); end
    end
  endtask

  task automatic test_truncated();
    logic [7:0] exp_d [5]    = '{8'h08, 8'h55, 8'h04, 8'h66, 8'h2A};
    logic       exp_act [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    push_hdr(8'h08); push(8'h55); push_hdr(8'h04); push(8'h66); push(8'h2A);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) bus.read_enb = 1'b0;
      checks++; if (bus.data_out !== exp_d[i]) begin errors++; $display("FAIL trunc_dout[%0d] got=%0h exp=%0h", i, bus.data_out, exp_d[i]); end
      checks++; if (bus.pkt_active !== exp_act[i]) begin errors++; $display("FAIL trunc_active[%0d] got=%0h exp=%0h", i, bus.pkt_active, exp_act[i]); end
      checks++; if (bus.pkt_done !== exp_done[i]) begin errors++; $display("FAIL trunc_done[%0d] got=%0h exp=%0h", i, bus.pkt_done, exp_done[i]); end
    end
  endtask

  task automatic test_soft_reset();
    logic [7:0] exp_d [3]    = '{8'h04, 8'h99, 8'h33};
    logic       exp_act [3]  = '{1'b1, 1'b1, 1'b0};
    logic       exp_done [3] = '{1'b0, 1'b0, 1'b1};
    push_hdr(8'h14);
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
    push(8'h77); push(8'hC1); push(8'hC2);
    bus.read_enb = 1'b1;
    tick(); tick();
    bus.read_enb = 1'b0;
    checks++; if (bus.fill_level !== 5'd7) begin errors++; $display("FAIL srst_pre_fill got=%0d exp=7", bus.fill_level); end
    checks++; if (bus.pkt_active !== 1'b1) begin errors++; $display("FAIL srst_pre_active got=%0h exp=1", bus.pkt_active); end
    bus.soft_reset = 1'b1; bus.write_enb = 1'b1; bus.read_enb = 1'b1; bus.data_in = 8'hDD;
    tick();
    bus.soft_reset = 1'b0; bus.write_enb = 1'b0; bus.read_enb = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL srst_empty got=%0h exp=1", bus.empty); end
    checks++; if (bus.fill_level !== 5'd0) begin errors++; $display("FAIL srst_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL srst_dout got=%0h exp=0", bus.data_out); end
    checks++; if (bus.pkt_active !== 1'b0) begin errors++; $display("FAIL srst_active got=%0h exp=0", bus.pkt_active); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL srst_done got=%0h exp=0", bus.pkt_done); end
    push_hdr(8'h04); push(8'h99); push(8'h33);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) bus.read_enb = 1'b0;
      checks++; if (bus.data_out !== exp_d[i]) begin errors++; $display("FAIL srst_dout[%0d] got=%0h exp=%0h", i, bus.data_out, exp_d[i]); end
      checks++; if (bus.pkt_active !== exp_act[i]) begin errors++; $display("FAIL srst_active[%0d] got=%0h exp=%0h", i, bus.pkt_active, exp_act[i]); end
      checks++; if (bus.pkt_done !== exp_done[i]) begin errors++; $display("FAIL srst_done[%0d] got=%0h exp=%0h", i, bus.pkt_done, exp_done[i]); end
    end
  endtask

  task automatic test_async_reset();
    push_hdr(8'h14);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5); push(8'hD6);
    bus.read_enb = 1'b1;
    tick(); tick();
    bus.read_enb = 1'b0;
    checks++; if (bus.fill_level !== 5'd5) begin errors++; $display("FAIL arst_pre_fill got=%0d exp=5", bus.fill_level); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL arst_empty got=%0h exp=1", bus.empty); end
    checks++; if (bus.fill_level !== 5'd0) begin errors++; $display("FAIL arst_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL arst_dout got=%0h exp=0", bus.data_out); end
    checks++; if (bus.pkt_active !== 1'b0) begin errors++; $display("FAIL arst_active got=%0h exp=0", bus.pkt_active); end
    tick();
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL arst_done got=%0h exp=0", bus.pkt_done); end
    #2;
    reset = 1'b0;
    push(8'h88);
    checks++; if (bus.fill_level !== 5'd1) begin errors++; $display("FAIL arst_first_wr got=%0d exp=1", bus.fill_level); end
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    checks++; if (bus.data_out !== 8'h88) begin errors++; $display("FAIL arst_dout_rd got=%0h exp=88", bus.data_out); end
    checks++; if (bus.pkt_active !== 1'b0) begin errors++; $display("FAIL arst_active_rd got=%0h exp=0", bus.pkt_active); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL arst_done_rd got=%0h exp=0", bus.pkt_done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_packet();
    test_full();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_truncated();
    test_soft_reset();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
